// File: rtl/seq_det_prog.sv
// Programmable serial bit-sequence detector: run-time pattern of up to MAX_LEN bits,
// optional overlap, registered detect pulse and saturating match counter.
module seq_det_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy
);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [LEN_W-1:0]   cfg_eff_len;
    logic               shift;
    logic [MAX_LEN-1:0] next_hist;
    logic [LEN_W-1:0]   shift_fill;
    logic [LEN_W-1:0]   next_fill;
    logic [LEN_W-1:0]   next_len;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Lengths below 2 are forced to 2 and anything beyond MAX_LEN clamps to MAX_LEN.
    always_comb begin
        cfg_eff_len = cfg_len;
        if (cfg_len < LEN_W'(2)) begin
            cfg_eff_len = LEN_W'(2);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_eff_len = LEN_W'(MAX_LEN);
        end
    end

    // Match is evaluated on the post-edge history so det needs no extra cycle.
    always_comb begin
        shift      = din_valid & ~cfg_load;
        next_hist  = shift ? {hist[MAX_LEN-2:0], din} : hist;
        shift_fill = (fill < len_q) ? fill + LEN_W'(1) : fill;

        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        match = shift && (shift_fill == len_q) &&
                (((next_hist ^ pat_q) & len_mask) == '0);

        next_fill = fill;
        if (cfg_load) begin
            next_fill = '0;
        end else if (shift) begin
            next_fill = (match && !ovl_q) ? '0 : shift_fill;
        end

        next_len = cfg_load ? cfg_eff_len : len_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q       <= '0;
            len_q       <= LEN_W'(MAX_LEN);
            ovl_q       <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            det         <= 1'b0;
            match_count <= '0;
            busy        <= 1'b1;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_eff_len;
                ovl_q <= cfg_overlap;
            end
            hist <= next_hist;
            fill <= next_fill;
            det  <= match;
            busy <= (next_fill < next_len);
            // A clear wins over a simultaneous match; the count never wraps.
            if (cnt_clr) begin
                match_count <= '0;
            end else if (match && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog (MAX_LEN = 8, CNT_W = 3).
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               cnt_clr;
    logic               det;
    logic [CNT_W-1:0]   match_count;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .cnt_clr     (cnt_clr),
        .det         (det),
        .match_count (match_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic apply_stimulus(input logic valid, input logic d, input logic clr);
        @(negedge clk);
        cfg_load  = 1'b0;
        din_valid = valid;
        din       = d;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    // din_valid is held high with din = 1 during the load to show that sample is dropped.
    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ov);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        din_valid   = 1'b1;
        din         = 1'b1;
        cnt_clr     = 1'b0;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic send_seq(input string tag, input logic [31:0] bits, input int n,
                            input logic [31:0] exp_det);
        for (int i = n - 1; i >= 0; i--) begin
            apply_stimulus(1'b1, bits[i], 1'b0);
            check_output($sformatf("%s_det%0d", tag, n - i), 32'(det), 32'(exp_det[i]));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        din_valid   = 1'b0;
        din         = 1'b0;
        cnt_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_det",  32'(det), 32'd0);
        check_output("rst_cnt",  32'(match_count), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] basic non-overlapping detection");
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        check_output("basic_busy_load", 32'(busy), 32'd1);
        send_seq("basic", 32'b0100101001, 10, 32'b0000100001);
        check_output("basic_cnt", 32'(match_count), 32'd2);

        $display("[TB] overlapping vs non-overlapping");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("clr_cnt", 32'(match_count), 32'd0);
        check_output("clr_det", 32'(det), 32'd0);
        load_cfg(8'b0000_1001, 4'd4, 1'b1);
        send_seq("ovl1", 32'b1001001, 7, 32'b0001001);
        check_output("ovl1_cnt",  32'(match_count), 32'd2);
        check_output("ovl1_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        send_seq("ovl0", 32'b1001001, 7, 32'b0001000);
        check_output("ovl0_cnt",  32'(match_count), 32'd1);
        check_output("ovl0_busy", 32'(busy), 32'd1);

        $display("[TB] valid gaps");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        for (int b = 0; b < 4; b++) begin
            apply_stimulus(1'b1, (b == 0 || b == 3), 1'b0);
            check_output($sformatf("gap_bit%0d", b), 32'(det), (b == 3) ? 32'd1 : 32'd0);
            for (int g = 0; g < 3; g++) begin
                apply_stimulus(1'b0, 1'b1, 1'b0);
                check_output($sformatf("gap_idle%0d_%0d", b, g), 32'(det), 32'd0);
            end
        end
        check_output("gap_cnt", 32'(match_count), 32'd1);

        $display("[TB] length clamping");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        load_cfg(8'hA5, 4'd12, 1'b0);
        send_seq("clamp12", 32'b010110100101, 12, 32'b000000000001);
        check_output("clamp12_cnt", 32'(match_count), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        load_cfg(8'h02, 4'd0, 1'b1);
        send_seq("len0", 32'b10010, 5, 32'b01001);
        check_output("len0_cnt", 32'(match_count), 32'd2);

        $display("[TB] counter saturation and clear");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        send_seq("sat", 32'b1111111111, 10, 32'b0111111111);
        check_output("sat_cnt", 32'(match_count), 32'd7);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("clr_match_det", 32'(det), 32'd1);
        check_output("clr_match_cnt", 32'(match_count), 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("after_clr_cnt", 32'(match_count), 32'd1);

        $display("[TB] reset and reload mid-sequence");
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        send_seq("pre_rst", 32'b1001, 4, 32'b0001);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_det",  32'(det), 32'd0);
        check_output("async_cnt",  32'(match_count), 32'd0);
        check_output("async_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        send_seq("mid_a", 32'b100, 3, 32'b000);
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        send_seq("mid_rst1", 32'b1, 1, 32'b0);
        check_output("mid_rst_busy", 32'(busy), 32'd1);
        send_seq("mid_rst2", 32'b001, 3, 32'b001);
        send_seq("mid_b", 32'b100, 3, 32'b000);
        load_cfg(8'b0000_1001, 4'd4, 1'b0);
        send_seq("mid_ld1", 32'b1, 1, 32'b0);
        check_output("mid_ld_busy", 32'(busy), 32'd1);
        send_seq("mid_ld2", 32'b001, 3, 32'b001);
        check_output("mid_ld_cnt", 32'(match_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
